// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bank: PS/2 key codes, ring FSM states,
// BCD time-of-day record and the BCD minute adder used by snooze.
package alarm_pkg;

    // PS/2 set-2 make codes recognised by the key decoder
    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_S = 8'h1B;  // store set time into selected channel
    localparam logic [7:0] KEY_A = 8'h1C;  // toggle arm of selected channel
    localparam logic [7:0] KEY_C = 8'h21;  // acknowledge all
    localparam logic [7:0] KEY_Z = 8'h1A;  // snooze (only when snooze is built in)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_MISSED = 2'd2
    } ring_state_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } bcd_time_t;

    // Add add_min minutes to a BCD time. Minutes past 59 wrap and carry into
    // the hour; hour 23 carries to 00. Seconds pass through untouched.
    function automatic bcd_time_t bcd_add_minutes(input bcd_time_t t, input logic [3:0] add_min);
        logic [7:0] min_bin;
        logic [7:0] hour_bin;
        bcd_time_t  r;
        min_bin  = t.min[7:4] * 8'd10 + {4'd0, t.min[3:0]} + {4'd0, add_min};
        hour_bin = t.hour[7:4] * 8'd10 + {4'd0, t.hour[3:0]};
        if (min_bin >= 8'd60) begin
            min_bin  = min_bin - 8'd60;
            hour_bin = (hour_bin >= 8'd23) ? 8'd0 : hour_bin + 8'd1;
        end
        r.sec  = t.sec;
        r.min  = {4'(min_bin / 8'd10), 4'(min_bin % 8'd10)};
        r.hour = {4'(hour_bin / 8'd10), 4'(hour_bin % 8'd10)};
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored BCD time, arm bit, latched pending flag and the
// time comparator. With ALARM_SNOOZE_EN defined it also carries the snooze
// adder that pushes the stored time forward by SNOOZE_MIN minutes.
module alarm_channel
    import alarm_pkg::*;
`ifdef ALARM_SNOOZE_EN
#(
    parameter int SNOOZE_MIN = 5
)
`endif
(
    input  logic      clk,
    input  logic      reset,
    input  bcd_time_t set_time,
    input  bcd_time_t rtc_time,
    input  logic      sec_tick,
    input  logic      load,
    input  logic      toggle,
    input  logic      clear_all,
`ifdef ALARM_SNOOZE_EN
    input  logic      snooze,
`endif
    output logic      armed,
    output logic      pending,
    output logic      pending_next
);

    bcd_time_t time_q, time_d;
    logic      armed_q, armed_d;
    logic      pending_q, pending_d;
    logic      match;

    // Only a fresh RTC second can fire; a static equal time never retriggers.
    assign match = sec_tick && armed_q && (time_q == rtc_time);

`ifdef ALARM_SNOOZE_EN
    bcd_time_t snooze_time;
    assign snooze_time = bcd_add_minutes(time_q, 4'(SNOOZE_MIN));
`endif

    // Next-state for stored time, arm and pending; a match always wins over clears.
    always_comb begin
        time_d    = time_q;
        armed_d   = armed_q;
        pending_d = pending_q;
        if (load) begin
            time_d    = set_time;
            armed_d   = 1'b1;
            pending_d = 1'b0;
        end else if (toggle) begin
            armed_d = ~armed_q;
            if (armed_q) begin
                pending_d = 1'b0;
            end
        end
        if (clear_all) begin
            pending_d = 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        if (snooze && pending_q) begin
            time_d    = snooze_time;
            armed_d   = 1'b1;
            pending_d = 1'b0;
        end
`endif
        if (match) begin
            pending_d = 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q    <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            time_q    <= time_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

    assign armed        = armed_q;
    assign pending      = pending_q;
    assign pending_next = pending_d;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm clock core: PS/2 key decode, RTC second-edge detect,
// N_CH alarm channels and the IDLE/RING/MISSED ring controller.
// Optional feature: define ALARM_SNOOZE_EN to build in the snooze key (Z).
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_MIN = 5
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      key_code,
    input  logic            key_tick,
    input  logic [7:0]      set_hour,
    input  logic [7:0]      set_min,
    input  logic [7:0]      set_sec,
    input  logic [7:0]      rtc_hour,
    input  logic [7:0]      rtc_min,
    input  logic [7:0]      rtc_sec,
    output logic [1:0]      sel_ch,
    output logic [N_CH-1:0] armed,
    output logic [N_CH-1:0] pending,
    output logic            ring,
    output logic            missed
);

    // Parameter range guard: an out-of-range build elaborates this named
    // marker block, which makes the bad configuration visible in the hierarchy.
    if (N_CH < 1 || N_CH > 4 || RING_SEC < 1 || RING_SEC > 255 ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 9) begin : g_param_out_of_range
    end

    bcd_time_t   set_time, rtc_time;
    logic [1:0]  sel_ch_q, sel_ch_d;
    logic [7:0]  prev_sec_q, prev_sec_d;
    logic        sec_tick_q, sec_tick_d;
    ring_state_e state_q, state_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [7:0]  cnt_inc;
    logic        ring_q, ring_d;
    logic        missed_q, missed_d;
    logic        key_s, key_a, key_c;
    logic [N_CH-1:0] pending_next;
    logic        any_next, new_set;

    assign set_time = '{hour: set_hour, min: set_min, sec: set_sec};
    assign rtc_time = '{hour: rtc_hour, min: rtc_min, sec: rtc_sec};

    assign key_s = key_tick && (key_code == KEY_S);
    assign key_a = key_tick && (key_code == KEY_A);
    assign key_c = key_tick && (key_code == KEY_C);

`ifdef ALARM_SNOOZE_EN
    logic snooze_go;
    assign snooze_go = key_tick && (key_code == KEY_Z) && (state_q != ST_IDLE);
`endif

    // Channel select keys; digits beyond the built channel count are ignored.
    always_comb begin
        sel_ch_d = sel_ch_q;
        if (key_tick) begin
            case (key_code)
                KEY_1: sel_ch_d = 2'd0;
                KEY_2: if (N_CH >= 2) sel_ch_d = 2'd1;
                KEY_3: if (N_CH >= 3) sel_ch_d = 2'd2;
                KEY_4: if (N_CH >= 4) sel_ch_d = 2'd3;
                default: ;
            endcase
        end
    end

    // Second-edge detect: one registered pulse whenever the RTC seconds change.
    always_comb begin
        prev_sec_d = rtc_sec;
        sec_tick_d = (rtc_sec != prev_sec_q);
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic ch_sel;
        assign ch_sel = (sel_ch_q == 2'(gi));

        alarm_channel
`ifdef ALARM_SNOOZE_EN
            #(.SNOOZE_MIN(SNOOZE_MIN))
`endif
            u_ch (
                .clk         (clk),
                .reset       (reset),
                .set_time    (set_time),
                .rtc_time    (rtc_time),
                .sec_tick    (sec_tick_q),
                .load        (key_s && ch_sel),
                .toggle      (key_a && ch_sel),
                .clear_all   (key_c),
`ifdef ALARM_SNOOZE_EN
                .snooze      (snooze_go),
`endif
                .armed       (armed[gi]),
                .pending     (pending[gi]),
                .pending_next(pending_next[gi])
            );
    end

    // The controller reacts to the pending vector being written this edge, so
    // RING is entered together with the pending bit that caused it.
    assign any_next = |pending_next;
    assign new_set  = |(pending_next & ~pending);

    // Ring controller next-state and registered output decodes.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        cnt_inc    = ring_cnt_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (any_next) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                end
            end
            ST_RING: begin
                if (!any_next) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else if (sec_tick_q) begin
                    ring_cnt_d = cnt_inc;
                    if (cnt_inc == 8'(RING_SEC)) begin
                        state_d = ST_MISSED;
                    end
                end
            end
            ST_MISSED: begin
                if (!any_next) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else if (new_set) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ring_cnt_d = '0;
            end
        endcase
        ring_d   = (state_q == ST_RING);
        missed_d = (state_q == ST_MISSED);
    end

    // Top-level registers; reset also samples the current RTC second so the
    // first cycle out of reset does not produce a spurious second tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ch_q   <= 2'd0;
            prev_sec_q <= rtc_sec;
            sec_tick_q <= 1'b0;
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            sel_ch_q   <= sel_ch_d;
            prev_sec_q <= prev_sec_d;
            sec_tick_q <= sec_tick_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            ring_q     <= ring_d;
            missed_q   <= missed_d;
        end
    end

    assign sel_ch = sel_ch_q;
    assign ring   = ring_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Testbench for alarm_bank: directed scenarios plus randomized key/RTC
// traffic, with a time-of-day reference model feeding a per-cycle scoreboard.
module tb_alarm_bank;

    localparam int N_CH       = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 5;

    localparam logic [7:0] K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26, K4 = 8'h25;
    localparam logic [7:0] KS = 8'h1B, KA = 8'h1C, KC = 8'h21, KZ = 8'h1A;

    localparam int M_IDLE = 0, M_RING = 1, M_MISSED = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      key_code = 8'h00;
    logic            key_tick = 1'b0;
    logic [7:0]      set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
    logic [7:0]      rtc_hour = 8'h00, rtc_min = 8'h00, rtc_sec = 8'h00;
    logic [1:0]      sel_ch;
    logic [N_CH-1:0] armed, pending;
    logic            ring, missed;

    always #5 clk = ~clk;

    alarm_bank #(.N_CH(N_CH), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_tick(key_tick),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .rtc_hour(rtc_hour), .rtc_min(rtc_min), .rtc_sec(rtc_sec),
        .sel_ch(sel_ch), .armed(armed), .pending(pending),
        .ring(ring), .missed(missed)
    );

    typedef struct {
        logic [1:0]      sel;
        logic [N_CH-1:0] arm;
        logic [N_CH-1:0] pend;
        logic            ring;
        logic            missed;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: times kept as seconds-of-day, alarm state as plain arrays.
    int  rtc_sod = 0;
    int  set_sod = 0;
    int  m_sel;
    bit  m_arm[N_CH];
    bit  m_pend[N_CH];
    int  m_time[N_CH];
    int  m_mode, m_cnt;
    bit  m_ring, m_missed, m_tick;
    int  m_prev_sec;

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model across one clock edge with the inputs just driven.
    task automatic model_step(input bit rst, input bit tick, input logic [7:0] code);
        bit hit[N_CH];
        bit old_pend[N_CH];
        bit any, fresh;
        int old_mode, k;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                m_arm[i] = 0; m_pend[i] = 0; m_time[i] = 0;
            end
            m_sel = 0; m_mode = M_IDLE; m_cnt = 0;
            m_ring = 0; m_missed = 0; m_tick = 0;
            m_prev_sec = rtc_sod % 60;
            return;
        end
        old_mode = m_mode;
        for (int i = 0; i < N_CH; i++) begin
            hit[i]      = m_tick && m_arm[i] && (m_time[i] == rtc_sod);
            old_pend[i] = m_pend[i];
        end
        if (tick) begin
            case (code)
                K1: k = 1;
                K2: k = 2;
                K3: k = 3;
                K4: k = 4;
                default: k = 0;
            endcase
            if (k != 0 && k <= N_CH) m_sel = k - 1;
            if (code == KS) begin
                m_time[m_sel] = set_sod; m_arm[m_sel] = 1; m_pend[m_sel] = 0;
            end
            if (code == KA) begin
                if (m_arm[m_sel]) begin m_arm[m_sel] = 0; m_pend[m_sel] = 0; end
                else m_arm[m_sel] = 1;
            end
            if (code == KC) begin
                for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
            end
`ifdef ALARM_SNOOZE_EN
            if (code == KZ && old_mode != M_IDLE) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (old_pend[i]) begin
                        m_time[i] = (m_time[i] + SNOOZE_MIN * 60) % 86400;
                        m_arm[i]  = 1;
                        m_pend[i] = 0;
                    end
                end
            end
`endif
        end
        any = 0; fresh = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit[i]) m_pend[i] = 1;
            if (m_pend[i]) any = 1;
            if (m_pend[i] && !old_pend[i]) fresh = 1;
        end
        case (old_mode)
            M_IDLE:  if (any) begin m_mode = M_RING; m_cnt = 0; end
            M_RING: begin
                if (!any) begin m_mode = M_IDLE; m_cnt = 0; end
                else if (m_tick) begin
                    m_cnt++;
                    if (m_cnt == RING_SEC) m_mode = M_MISSED;
                end
            end
            default: begin
                if (!any) begin m_mode = M_IDLE; m_cnt = 0; end
                else if (fresh) begin m_mode = M_RING; m_cnt = 0; end
            end
        endcase
        m_ring   = (old_mode == M_RING);
        m_missed = (old_mode == M_MISSED);
        m_tick     = ((rtc_sod % 60) != m_prev_sec);
        m_prev_sec = rtc_sod % 60;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected outputs.
    task automatic apply(input bit rst, input bit tick, input logic [7:0] code);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        key_tick = tick;
        key_code = code;
        set_hour = to_bcd(set_sod / 3600);
        set_min  = to_bcd((set_sod / 60) % 60);
        set_sec  = to_bcd(set_sod % 60);
        rtc_hour = to_bcd(rtc_sod / 3600);
        rtc_min  = to_bcd((rtc_sod / 60) % 60);
        rtc_sec  = to_bcd(rtc_sod % 60);
        model_step(rst, tick, code);
        e.sel = 2'(m_sel);
        for (int i = 0; i < N_CH; i++) begin
            e.arm[i]  = m_arm[i];
            e.pend[i] = m_pend[i];
        end
        e.ring   = m_ring;
        e.missed = m_missed;
        exp_q.push_back(e);
        if (tick)
            $display("key code=0x%02h rst=%0d rtc=%02h:%02h:%02h set=%02h:%02h:%02h",
                     code, rst, rtc_hour, rtc_min, rtc_sec, set_hour, set_min, set_sec);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 8'h00);
    endtask

    task automatic key(input logic [7:0] code);
        apply(0, 1, code);
    endtask

    task automatic do_reset();
        apply(1, 0, 8'h00);
        apply(1, 0, 8'h00);
    endtask

    // Monitor: every cycle the DUT presents a new output set one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_sel_ch",  32'(sel_ch),  32'(e.sel));
                check("sb_armed",   32'(armed),   32'(e.arm));
                check("sb_pending", 32'(pending), 32'(e.pend));
                check("sb_ring",    32'(ring),    32'(e.ring));
                check("sb_missed",  32'(missed),  32'(e.missed));
            end
        end
    end

    initial begin
        int r;
        logic [7:0] codes [9];
        codes[0] = K1; codes[1] = K2; codes[2] = K3; codes[3] = K4;
        codes[4] = KS; codes[5] = KA; codes[6] = KC; codes[7] = KZ; codes[8] = 8'h00;

        // Reset state
        do_reset();
        idle(1);
        check("reset_outputs", {sel_ch, armed, pending, ring, missed}, 32'd0);

        // Channel 2 alarm at 07:30:00 fires and rings
        rtc_sod = hms(7, 29, 58);
        idle(3);
        key(K2);
        set_sod = hms(7, 30, 0);
        key(KS);
        idle(2);
        rtc_sod = hms(7, 29, 59);
        idle(4);
        check("no_early_match", 32'(pending), 32'd0);
        rtc_sod = hms(7, 30, 0);
        idle(1);
        idle(1);
        idle(1);
        check("match_pending", 32'(pending), 32'b0010);
        check("ring_not_yet", 32'(ring), 32'd0);
        idle(1);
        check("ring_rises", 32'(ring), 32'd1);

        // Acknowledge, then a static equal RTC must not retrigger
        key(KC);
        idle(50);
        check("static_no_pending", 32'(pending), 32'd0);
        check("static_no_ring", {ring, missed}, 32'd0);

        // Ring timeout after RING_SEC seconds without acknowledge
        rtc_sod = hms(7, 29, 59);
        idle(4);
        rtc_sod = hms(7, 30, 0);
        idle(4);
        check("ring_again", 32'(ring), 32'd1);
        for (int s = 1; s <= 3; s++) begin
            rtc_sod = hms(7, 30, s);
            idle(4);
            if (s == 2) check("still_ringing", {ring, missed}, 32'b10);
        end
        check("timed_out", {ring, missed}, 32'b01);
        key(KC);
        idle(3);
        check("ack_missed", {pending, ring, missed}, 32'd0);

        // Match and acknowledge in the same cycle: the match wins
        do_reset();
        key(K1);
        set_sod = hms(8, 0, 0);
        key(KS);
        rtc_sod = hms(7, 59, 59);
        idle(4);
        rtc_sod = hms(8, 0, 0);
        idle(1);
        key(KC);
        idle(1);
        check("match_beats_clear", 32'(pending), 32'b0001);
        idle(1);
        check("match_beats_clear_ring", 32'(ring), 32'd1);
        key(KC);
        idle(3);

        // Snooze (or its absence) on channel 1 at 23:58:10
        do_reset();
        key(K2);
        set_sod = hms(23, 58, 10);
        key(KS);
        rtc_sod = hms(23, 58, 9);
        idle(4);
        rtc_sod = hms(23, 58, 10);
        idle(4);
        check("snooze_ringing", {pending, ring}, {4'b0010, 1'b1});
        key(KZ);
        idle(3);
`ifdef ALARM_SNOOZE_EN
        check("snooze_cleared", {armed, pending, ring, missed}, {4'b0010, 4'b0000, 2'b00});
        rtc_sod = hms(0, 3, 9);
        idle(4);
        rtc_sod = hms(0, 3, 10);
        idle(4);
        check("snooze_new_time", 32'(pending), 32'b0010);
`else
        check("z_ignored", {pending, ring}, {4'b0010, 1'b1});
`endif
        key(KC);
        idle(3);

        // Reset in the middle of RING, with a coincident key press
        key(K3);
        set_sod = hms(12, 0, 0);
        key(KS);
        rtc_sod = hms(11, 59, 59);
        idle(4);
        rtc_sod = hms(12, 0, 0);
        idle(4);
        check("pre_reset_ring", 32'(ring), 32'd1);
        apply(1, 1, K2);
        idle(1);
        check("reset_mid_ring", {sel_ch, armed, pending, ring, missed}, 32'd0);
        key(KA);
        rtc_sod = hms(23, 59, 59);
        idle(4);
        rtc_sod = hms(0, 0, 0);
        idle(4);
        check("reset_time_zero", 32'(pending), 32'b0001);
        key(KC);
        idle(3);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) rtc_sod = (rtc_sod + 1) % 86400;
            if ($urandom_range(0, 59) == 0) rtc_sod = $urandom_range(0, 86399);
            if ($urandom_range(0, 9) == 0) set_sod = (rtc_sod + $urandom_range(0, 8)) % 86400;
            r = $urandom_range(0, 8);
            if (r == 8) codes[8] = 8'($urandom_range(0, 255));
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0, codes[r]);
        end
        idle(3);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
